// File: rtl/gcd_job_ctrl.sv
// Round-robin GCD job sequencer in front of the GCD-program CPU; one job in flight at a time.
// Optional: define GCD_CTRL_ZERO_BYPASS_EN to answer zero-operand jobs directly without running the CPU.
module gcd_job_ctrl #(
  parameter logic [31:0] HALT_PC      = 32'h0000_0040,
  parameter int          RST_CYCLES   = 2,
  parameter int          START_CYCLES = 6,
  parameter int          TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        cpu_rst_n,
  output logic        cpu_calc_start,
  output logic [31:0] cpu_gcd_a,
  output logic [31:0] cpu_gcd_b,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_gcd_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CPU_RST = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] START_LAST   = 16'(START_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic        rr_last;
  logic        job_id;
  logic        halt_q;
  logic        grant0;
  logic        grant1;
  logic        gnt_id;
  logic [31:0] gnt_a;
  logic [31:0] gnt_b;
  logic        zero_job;
  logic        pc_at_halt;

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // valid never waits on ready, and ready is only offered while IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = rr_last;
        grant1 = !rr_last;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign gnt_id     = grant1;
  assign gnt_a      = grant1 ? req1_a : req0_a;
  assign gnt_b      = grant1 ? req1_b : req0_b;
  assign pc_at_halt = (cpu_pc == HALT_PC);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

`ifdef GCD_CTRL_ZERO_BYPASS_EN
  assign zero_job = (gnt_a == 32'd0) || (gnt_b == 32'd0);
`else
  assign zero_job = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= 16'd0;
      rr_last        <= 1'b1;
      job_id         <= 1'b0;
      halt_q         <= 1'b0;
      cpu_rst_n      <= 1'b0;
      cpu_calc_start <= 1'b0;
      cpu_gcd_a      <= 32'd0;
      cpu_gcd_b      <= 32'd0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_result     <= 32'd0;
      rsp_timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 || grant1) begin
            cpu_gcd_a <= gnt_a;
            cpu_gcd_b <= gnt_b;
            job_id    <= gnt_id;
            rr_last   <= gnt_id;
            cnt       <= 16'd0;
            if (zero_job) begin
              // gcd(0,x)=x and gcd(0,0)=0, so OR-ing the operands is the answer
              rsp_valid   <= 1'b1;
              rsp_id      <= gnt_id;
              rsp_result  <= gnt_a | gnt_b;
              rsp_timeout <= 1'b0;
              state       <= S_RESP;
            end else begin
              state <= S_CPU_RST;
            end
          end
        end
        S_CPU_RST: begin
          if (cnt == RST_LAST) begin
            cnt            <= 16'd0;
            cpu_rst_n      <= 1'b1;
            cpu_calc_start <= 1'b1;
            state          <= S_START;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_START: begin
          if (cnt == START_LAST) begin
            cnt            <= 16'd0;
            cpu_calc_start <= 1'b0;
            halt_q         <= 1'b0;
            state          <= S_RUN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RUN: begin
          // A single HALT_PC sample can be a passing branch; require two in a row.
          halt_q <= pc_at_halt;
          if (pc_at_halt && halt_q) begin
            rsp_result  <= cpu_gcd_result;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_id      <= job_id;
            cpu_rst_n   <= 1'b0;
            state       <= S_RESP;
          end else if (cnt == TIMEOUT_LAST) begin
            rsp_result  <= 32'd0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_id      <= job_id;
            cpu_rst_n   <= 1'b0;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          cpu_rst_n      <= 1'b0;
          cpu_calc_start <= 1'b0;
          rsp_valid      <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule
